axi_lite_reg_slave: RTL

//  AXI4-Lite responder with a bank of NUM_REGS read/write 32-bit registers.
//  It is the slave end of the register path that the master BFM tests drive.
//  It accepts AW and W independently, applies byte strobes, and returns B and R.
//  Out-of-range accesses get SLVERR. All registers drive reg_out for user logic.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_chan_hold.sv | 49 ++++
 rtl/axi_lite_reg_slave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [AXI_DATA_W-1:0] strb_mask(input logic [AXI_STRB_W-1:0] strb);
        logic [AXI_DATA_W-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < AXI_STRB_W; k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_lite_chan_hold.sv
// One-entry valid/payload hold for an AXI channel with a registered ready.
module axi_lite_chan_hold #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    input  logic             block_i,
    input  logic             clr_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_q, full_d;
    logic             ready_q, ready_d;
    logic [Width-1:0] data_q, data_d;

    // block_i is the next-cycle block so ready stays a pure flop output.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (valid_i && ready_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
        ready_d = !full_d && !block_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS strobe-writable 32-bit registers on reg_out.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [AXI_DATA_W*NUM_REGS-1:0]    reg_out
);

    localparam int unsigned AddrW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IdxW  = AddrW - 2;
    localparam int unsigned WPayW = AXI_DATA_W + AXI_STRB_W;

    logic [NUM_REGS-1:0][AXI_DATA_W-1:0] regs_q, regs_d;

    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             ar_pend_q, ar_pend_d;
    logic [AddrW-1:0] ar_addr_q, ar_addr_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;

    logic             aw_full, w_full, commit;
    logic [AddrW-1:0] aw_addr;
    logic [WPayW-1:0] w_pay;
    logic [AXI_DATA_W-1:0] w_data, w_mask;
    logic [IdxW-1:0]  aw_idx, ar_idx;

    axi_lite_chan_hold #(
        .Width (AddrW)
    ) u_aw_hold (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .valid_i (S_AXI_AWVALID),
        .data_i  (S_AXI_AWADDR),
        .block_i (bvalid_d),
        .clr_i   (commit),
        .ready_o (S_AXI_AWREADY),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    axi_lite_chan_hold #(
        .Width (WPayW)
    ) u_w_hold (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .valid_i (S_AXI_WVALID),
        .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .block_i (bvalid_d),
        .clr_i   (commit),
        .ready_o (S_AXI_WREADY),
        .full_o  (w_full),
        .data_o  (w_pay)
    );

    // Holds can only be full while B is idle, so both full means commit now.
    assign commit = aw_full && w_full;
    assign w_data = w_pay[AXI_DATA_W-1:0];
    assign w_mask = strb_mask(w_pay[WPayW-1:AXI_DATA_W]);
    assign aw_idx = aw_addr[AddrW-1:2];
    assign ar_idx = ar_addr_q[AddrW-1:2];

    always_comb begin
        regs_d   = regs_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(aw_idx) == i) begin
                    regs_d[i] = (regs_q[i] & ~w_mask) | (w_data & w_mask);
                    bresp_d   = RESP_OKAY;
                end
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read data is taken from regs_q, so a same-edge commit is not yet visible.
    always_comb begin
        ar_pend_d = S_AXI_ARVALID && arready_q;
        ar_addr_d = ar_pend_d ? S_AXI_ARADDR : ar_addr_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (ar_pend_q) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_idx) == i) begin
                    rdata_d = regs_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d && !ar_pend_d;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            regs_q    <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ar_pend_q <= 1'b0;
            ar_addr_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ar_pend_q <= ar_pend_d;
            ar_addr_q <= ar_addr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_out       = regs_q;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], ar_addr_q[1:0]};

endmodule
